// File: rtl/sevenseg_pkg.sv
// Shared segment constants and decode helpers for the multiplexed 7-segment display driver.
// Segment order is {g,f,e,d,c,b,a}, active low.
package sevenseg_pkg;

  // Widest display the leading-zero helper handles.
  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Bit i set when digit i and every digit above it are zero; digit 0 is never blanked.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] digits);
    logic                  allZero;
    logic [MAX_DIGITS-1:0] m;
    allZero = 1'b1;
    m       = '0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      allZero = allZero & (digits[4*i +: 4] == 4'd0);
      m[i]    = allZero && (i > 0);
    end
    return m;
  endfunction

endpackage

// File: rtl/sevenseg_scan_driver_timer.sv
// Slot/digit timebase for the scan driver: slot counter, digit index and boundary pulses.
module seg_scan_timer #(
  parameter int SCAN_DIV = 50000,
  parameter int N_DIGITS = 8,
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1,
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] slot_cnt_o,
  output logic [IDX_W-1:0] digit_idx_o,
  output logic             slot_start_o,
  output logic             frame_end_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             slotWrap;

  always_comb begin
    slotWrap = (cnt_q == CNT_LAST);
    cnt_d    = slotWrap ? '0 : cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    if (slotWrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign slot_cnt_o   = cnt_q;
  assign digit_idx_o  = idx_q;
  assign slot_start_o = (cnt_q == '0);
  assign frame_end_o  = slotWrap && (idx_q == IDX_LAST);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Double-buffered multiplexed 7-segment driver with leading-zero blanking and anti-ghost gap.
// Optional macro DIM_PWM_EN adds a 4-bit brightness input that trims the anode on-time per slot.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS  = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lz_en,
`ifdef DIM_PWM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_sync
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] BLANK_V = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] slotCnt;
  logic [IDX_W-1:0] digitIdx;
  logic             slotStart;
  logic             frameEnd;

  seg_scan_timer #(
    .SCAN_DIV (SCAN_DIV),
    .N_DIGITS (N_DIGITS)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .slot_cnt_o   (slotCnt),
    .digit_idx_o  (digitIdx),
    .slot_start_o (slotStart),
    .frame_end_o  (frameEnd)
  );

  logic [4*N_DIGITS-1:0] stage_q, stage_d, shadow_q, shadow_d;
  logic [N_DIGITS-1:0]   stageDp_q, stageDp_d, shadowDp_q, shadowDp_d;
  logic [N_DIGITS-1:0]   mask_q, mask_d;
  logic                  pending_q, pending_d;
  logic                  fs_q, fs_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [4*MAX_DIGITS-1:0] padded;
  logic [MAX_DIGITS-1:0]   fullMask;
  logic [3:0]            curDigit;
  logic                  curDp, curBlank, pwmOn;

  // A load on the boundary cycle bypasses staging so it lands in the very next frame.
  always_comb begin
    stage_d    = stage_q;
    stageDp_d  = stageDp_q;
    pending_d  = pending_q;
    shadow_d   = shadow_q;
    shadowDp_d = shadowDp_q;
    mask_d     = mask_q;
    fs_d       = 1'b0;
    if (frameEnd && load) begin
      shadow_d   = bcd_in;
      shadowDp_d = dp_in;
      pending_d  = 1'b0;
      fs_d       = 1'b1;
    end else if (frameEnd && pending_q) begin
      shadow_d   = stage_q;
      shadowDp_d = stageDp_q;
      pending_d  = 1'b0;
      fs_d       = 1'b1;
    end else if (load) begin
      stage_d   = bcd_in;
      stageDp_d = dp_in;
      pending_d = 1'b1;
    end
    padded                 = '0;
    padded[4*N_DIGITS-1:0] = shadow_d;
    fullMask               = lz_mask(padded);
    if (fs_d) begin
      mask_d = fullMask[N_DIGITS-1:0];
    end
  end

`ifdef DIM_PWM_EN
  logic [3:0]  bright_q, brightEff;
  logic [31:0] onLen, offs;

  // Brightness taken live on the slot's first cycle, held for the rest of the slot.
  always_comb begin
    brightEff = slotStart ? brightness : bright_q;
    onLen     = ((32'(brightEff) + 32'd1) * 32'(SCAN_DIV - BLANK_CYC)) >> 4;
    offs      = 32'(slotCnt) - 32'(BLANK_CYC);
    pwmOn     = (offs < onLen);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bright_q <= '0;
    end else begin
      bright_q <= brightEff;
    end
  end
`else
  assign pwmOn = 1'b1;
`endif

  always_comb begin
    curDigit = '0;
    curDp    = 1'b0;
    curBlank = 1'b0;
    an_d     = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IDX_W'(i) == digitIdx) begin
        curDigit = shadow_q[4*i +: 4];
        curDp    = shadowDp_q[i];
        curBlank = mask_q[i];
        if ((slotCnt >= BLANK_V) && pwmOn) begin
          an_d[i] = 1'b0;
        end
      end
    end
    seg_d = (lz_en && curBlank) ? SEG_BLANK : bcd_to_seg(curDigit);
    dp_d  = ~curDp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q    <= '0;
      stageDp_q  <= '0;
      pending_q  <= 1'b0;
      shadow_q   <= '0;
      shadowDp_q <= '0;
      mask_q     <= {N_DIGITS{1'b1}} << 1;
      fs_q       <= 1'b0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      stage_q    <= stage_d;
      stageDp_q  <= stageDp_d;
      pending_q  <= pending_d;
      shadow_q   <= shadow_d;
      shadowDp_q <= shadowDp_d;
      mask_q     <= mask_d;
      fs_q       <= fs_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_sync = fs_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench for sevenseg_scan_driver (N_DIGITS=8, SCAN_DIV=8, BLANK_CYC=2).
// Define DIM_PWM_EN to also exercise the brightness input.
module tb_sevenseg_scan_driver;

  localparam int N  = 8;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = N * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        lz_en = 1'b1;
  logic [31:0] bcd_in = '0;
  logic [7:0]  dp_in = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frame_sync;
`ifdef DIM_PWM_EN
  logic [3:0]  brightness = 4'hF;
`endif

  sevenseg_scan_driver #(
    .N_DIGITS  (N),
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd_in     (bcd_in),
    .load       (load),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
`ifdef DIM_PWM_EN
    .brightness (brightness),
`endif
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_sync (frame_sync)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] segTable [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  // Reference model: absolute cycle count since reset plus the two data buffers.
  int          modelK = 0;
  logic [31:0] mStage = '0, mShadow = '0;
  logic [7:0]  mStageDp = '0, mShadowDp = '0;
  logic        mPending = 1'b0;
  logic [3:0]  mBright = 4'hF;
  logic [3:0]  curBright = 4'hF;

  task automatic applyStimulus(input logic rst, input logic ld, input logic [31:0] bcd,
                               input logic [7:0] dpv, input logic lz, input logic [3:0] br);
    exp_t e;
    int   pos, idx, c, onLen;
    logic blanked;
    @(negedge clk);
    reset  = rst;
    load   = ld;
    bcd_in = bcd;
    dp_in  = dpv;
    lz_en  = lz;
`ifdef DIM_PWM_EN
    brightness = br;
`endif
    if (rst) begin
      e         = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
      modelK    = 0;
      mStage    = '0;
      mShadow   = '0;
      mStageDp  = '0;
      mShadowDp = '0;
      mPending  = 1'b0;
    end else begin
      pos = modelK % FRAME;
      idx = pos / SD;
      c   = pos % SD;
      if (c == 0) mBright = br;
      onLen  = ((int'(mBright) + 1) * (SD - BC)) / 16;
      e.an   = 8'hFF;
      if (c >= BC && (c - BC) < onLen) e.an[idx] = 1'b0;
      blanked = lz && (idx > 0) && ((mShadow >> (4 * idx)) == 32'd0);
      e.seg  = blanked ? 7'h7F : segTable[mShadow[4*idx +: 4]];
      e.dp   = ~mShadowDp[idx];
      e.fs   = (pos == FRAME - 1) && (ld || mPending);
      if (pos == FRAME - 1 && ld) begin
        mShadow = bcd; mShadowDp = dpv; mPending = 1'b0;
      end else if (pos == FRAME - 1 && mPending) begin
        mShadow = mStage; mShadowDp = mStageDp; mPending = 1'b0;
      end else if (ld) begin
        mStage = bcd; mStageDp = dpv; mPending = 1'b1;
      end
      modelK++;
    end
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (an !== e.an) begin
      miscompares++;
      $display("[TB] FAIL an: got %h want %h at %0t", an, e.an, $time);
    end
    vectors++;
    if (seg !== e.seg) begin
      miscompares++;
      $display("[TB] FAIL seg: got %b want %b at %0t", seg, e.seg, $time);
    end
    vectors++;
    if (dp !== e.dp) begin
      miscompares++;
      $display("[TB] FAIL dp: got %b want %b at %0t", dp, e.dp, $time);
    end
    vectors++;
    if (frame_sync !== e.fs) begin
      miscompares++;
      $display("[TB] FAIL frame_sync: got %b want %b at %0t", frame_sync, e.fs, $time);
    end
    vectors++;
    if ($countones(~an) > 1) begin
      miscompares++;
      $display("[TB] FAIL an_onehot: got %h want at most one low bit at %0t", an, $time);
    end
  endtask

  // Monitor: one expected record per clock, compared just after the edge that produced it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic idle(input int n, input logic lz);
    repeat (n) applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, lz, curBright);
  endtask

  task automatic runToPos(input int p, input logic lz);
    for (int i = 0; i < FRAME && (modelK % FRAME) != p; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 8'h0, lz, curBright);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic        lzR;
    int          nz;
    int          waitCycles;

    applyStimulus(1'b1, 1'b0, 32'h0, 8'h0, 1'b1, curBright);
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h0, 1'b1, curBright);
    idle(128, 1'b1);

    runToPos(20, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0000_1234, 8'h00, 1'b1, curBright);
    idle(120, 1'b1);

    runToPos(30, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_1234, 8'h04, 1'b0, curBright);
    idle(140, 1'b0);

    runToPos(5, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h1111_1111, 8'h00, 1'b1, curBright);
    idle(10, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h9999_9999, 8'h00, 1'b1, curBright);
    idle(100, 1'b1);

    runToPos(FRAME - 1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h8765_4321, 8'h81, 1'b1, curBright);
    idle(70, 1'b1);

    runToPos(10, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0000_000B, 8'h00, 1'b1, curBright);
    idle(80, 1'b1);

    runToPos(40, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h5555_5555, 8'hFF, 1'b1, curBright);
    idle(3, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h0, 1'b1, curBright);
    idle(140, 1'b1);

`ifdef DIM_PWM_EN
    curBright = 4'd7;
    idle(128, 1'b1);
    curBright = 4'd0;
    idle(64, 1'b1);
    curBright = 4'd15;
    idle(64, 1'b1);
`endif

    lzR = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      r  = $urandom;
      nz = $urandom_range(0, 8);
      r  = (nz == 8) ? 32'h0 : (r >> (4 * nz));
      if ($urandom_range(0, 39) == 0) lzR = ~lzR;
`ifdef DIM_PWM_EN
      if ($urandom_range(0, 4) == 0) curBright = 4'($urandom_range(0, 15));
`endif
      applyStimulus(($urandom_range(0, 699) == 0), ($urandom_range(0, 11) == 0),
                    r, 8'($urandom), lzR, curBright);
    end
    idle(2, lzR);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    #3;
    if (expQ.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending records want 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
